sr_cmd_debounce: RTL
====================

SR_CMD_DEBOUNCE -- requirements
Module: sr_cmd_debounce

Upstream command stage: turns two raw asynchronous push-button levels into clean single-cycle s/r pulses for the set/reset flip-flop.

Interface
REQ-001 The parameter list SHALL be as follows.
  - DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a level change; legal range 1..255.
REQ-002 The port list SHALL be as follows (clock and reset first).
  - clk  input  1  sole clock; all state updates on its rising edge.
  - rst  input  1  reset; synchronous, active-high.
  - set_in  input  1  raw set button, asynchronous, may bounce.
  - clr_in  input  1  raw clear button, asynchronous, may bounce.
  - s  output  1  one-cycle set pulse to downstream flip-flop.
  - r  output  1  one-cycle reset pulse to downstream flip-flop.
  - conflict  output  1  one-cycle flag: simultaneous accepted presses.
  - q_model  output  1  expected downstream q after the pulses issued so far.
REQ-003 All outputs SHALL be registered; no combinational path from any input to any output.

Function
REQ-004 Each raw input SHALL pass through its own 2-flop synchronizer (sync1 -> sync2) before any other logic.
REQ-005 Each channel SHALL hold:
  - a debounced level db, and
  - an 8-bit counter cnt.
REQ-006 Each edge, per channel:
  - sync2 == db: cnt <= 0.
  - sync2 != db and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2 != db and cnt == DEBOUNCE_CYCLES-1: db <= sync2, cnt <= 0.
REQ-007 A single sync2 sample equal to db SHALL restart the count from 0 (bounce rejection); partial counts are never retained.
REQ-008 A channel SHALL raise its pulse request on the same edge its db goes 0->1; db 1->0 (release) SHALL produce no pulse.
REQ-009 Press latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges.
  - Input stable high before edge 1 -> pulse high for the cycle following edge DEBOUNCE_CYCLES+2.
REQ-010 s and r SHALL each be high for exactly one cycle per accepted press, however long the button is held.
REQ-011 Pulse resolution:
  - Set request only: s=1.
  - Clear request only: r=1.
  - Both on the same edge: s=1, r=0, conflict=1 (set priority, matching downstream); the clear request is discarded, not deferred.
REQ-012 s and r SHALL never be high in the same cycle.
REQ-013 conflict SHALL be high only in the cycle where REQ-011 suppresses r.
REQ-014 q_model SHALL update on the same edge as the pulses:
  - set to 1 when s is issued;
  - cleared to 0 when r is issued;
  - held otherwise.
REQ-015 Repeated presses of the same button SHALL each produce a pulse, even when q_model already matches.
REQ-016 A press and a release on the other channel in the same cycle SHALL be handled independently.

Reset
REQ-017 While rst=1 at an edge, the following SHALL all be loaded with 0: sync1, sync2, db, cnt (both channels), s, r, conflict, q_model.
REQ-018 Reset mid-count SHALL abandon the pending count; no pulse emitted for it.
REQ-019 A button held high through reset SHALL be treated as a new press after rst falls.
  - Pulse DEBOUNCE_CYCLES+2 edges after the first non-reset edge.

Verification (DEBOUNCE_CYCLES=4)
REQ-020 Clean press: set_in 0->1 held 20 cycles -> s=1 for one cycle after edge 6, q_model=1 from then; r=0, conflict=0 throughout.
REQ-021 Bounce: clr_in toggles 1,0,1,0 on alternate cycles then held 1 -> no r until 4 consecutive stable sync2 samples; then exactly one r pulse; q_model=0.
REQ-022 Simultaneous: set_in and clr_in rise in the same cycle -> s=1, r=0, conflict=1 in the same cycle; q_model=1.
REQ-023 Glitch rejection: set_in high 3 cycles, then low -> s never asserts; db stays 0.
REQ-024 Reset mid-count: set_in high, rst=1 for one cycle at edge 4, set_in held -> first s pulse after edge 10 (4+6); all outputs 0 during reset.
REQ-025 Sequence set, release, clear, release, set (each held 10 cycles) -> pulse order s, r, s; q_model 1,0,1; no overlap of s and r.

Source files
------------

// File: rtl/sr_cmd_debounce.sv
// Debounces two raw push-button levels and turns accepted presses into
// single-cycle s/r pulses, with set priority and a model of downstream q.
module sr_cmd_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s,
  output logic r,
  output logic conflict,
  output logic q_model
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  // Channel index 0 is the set button, index 1 the clear button.
  logic [1:0]      raw;
  logic [1:0]      sync1_q, sync1_d;
  logic [1:0]      sync2_q, sync2_d;
  logic [1:0]      db_q, db_d;
  logic [1:0][7:0] cnt_q, cnt_d;
  logic [1:0]      rise;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            conflict_q, conflict_d;
  logic            q_model_q, q_model_d;

  assign raw = {clr_in, set_in};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    db_d    = db_q;
    cnt_d   = cnt_q;
    rise    = '0;
    for (int ch = 0; ch < 2; ch++) begin
      // Any sample agreeing with the current level discards the partial count.
      if (sync2_q[ch] == db_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] >= CNT_LAST) begin
        db_d[ch]  = sync2_q[ch];
        cnt_d[ch] = '0;
        rise[ch]  = sync2_q[ch];
      end else begin
        cnt_d[ch] = cnt_q[ch] + 8'd1;
      end
    end

    // Set wins a same-edge collision; the clear request is dropped outright.
    s_d        = rise[0];
    r_d        = rise[1] & ~rise[0];
    conflict_d = rise[0] & rise[1];
    if (s_d) begin
      q_model_d = 1'b1;
    end else if (r_d) begin
      q_model_d = 1'b0;
    end else begin
      q_model_d = q_model_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_q       <= '0;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conflict_q <= 1'b0;
      q_model_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conflict_q <= conflict_d;
      q_model_q  <= q_model_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign conflict = conflict_q;
  assign q_model  = q_model_q;

endmodule
